a2d_conv_sched: RTL
===================

Name: a2d_conv_sched

Overview:
- Conversion scheduler for the shared 4-channel A2D on the DE0: battery, current, brake and torque.
- Decides which channel is converted next and paces conversions.
- Runs the two-transaction SPI exchange with the existing SPI master: a command, then a read-back.
- Holds the latest 12-bit result per channel and pulses a per-channel valid.
- Sits between the SPI master and SensorCondition / brake logic; the brake channel is scheduled with priority because it gates motor drive.

Parameters:
- FAST_SIM, 1: when 1, the inter-conversion interval is 512 clks; when 0, it is 16384 clks.
- BATT_CH, 3'd0: A2D channel number for battery.
- CURR_CH, 3'd1: A2D channel number for current.
- BRAKE_CH, 3'd3: A2D channel number for brake.
- TORQUE_CH, 3'd4: A2D channel number for torque.

Ports:
- clk  in  1  50MHz system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scheduling enable; low = finish current conversion, then idle
- wrt  out  1  one-clk start pulse to SPI master
- cmd  out  16  SPI command word, {2'b00, chnl[2:0], 11'h000}
- done  in  1  one-clk SPI-transaction-complete pulse
- rd_data  in  16  SPI read data; result is rd_data[11:0]
- batt  out  12  latest battery reading
- curr  out  12  latest current reading
- brake  out  12  latest brake reading
- torque  out  12  latest torque reading
- vld  out  4  one-clk update strobes {torque, brake, curr, batt}
- slot  out  3  current schedule slot index (debug/test)

Behaviour:
- Reset values:
  - wrt=0, cmd=16'h0000, batt=curr=torque=12'h000, vld=0, slot=0.
  - brake=12'h000, so brake_n reads "braking" and the motor is disabled until the first real brake sample.
- States: IDLE, CMD, WAIT_CMD, GAP, READ, WAIT_READ, STORE.
- IDLE:
  - Interval counter increments while en=1.
  - On terminal count (511 FAST_SIM / 16383) -> CMD; counter clears.
  - Counter is held at 0 while en=0.
- CMD: wrt=1 for exactly one clk, cmd = channel of current slot -> WAIT_CMD.
- WAIT_CMD: wait for done -> GAP.
- GAP: one idle clk, so SS_n deasserts between transactions -> READ.
- READ: wrt=1 for one clk; cmd uses the same channel (value ignored by A2D) -> WAIT_READ.
- WAIT_READ: wait for done -> STORE.
- STORE:
  - Latch rd_data[11:0] into the slot's channel register.
  - Pulse that channel's vld bit for one clk.
  - Advance slot with wrap-around -> IDLE.
- cmd holds its value from CMD through STORE; wrt is never high two consecutive clks.
- en deasserted mid-conversion: the sequence completes, including STORE; then the block stays in IDLE.
- en reasserted: first conversion starts one full interval later, from the current (un-reset) slot.
- done in IDLE, CMD, GAP, READ or STORE: ignored.
- done coincident with the wrt clk: ignored (not counted as completion).
- rd_data bits [15:12]: discarded.
- Asynchronous reset mid-conversion: all state, outputs and slot return to reset values immediately; no partial STORE.
- Latency: wrt of CMD occurs 1 clk after terminal count; vld pulses 1 clk after the second done.

Optional Feature:
- Macro: A2D_BRAKE_PRIO_EN.
- Defined: 8-slot table brake, batt, brake, curr, brake, torque, brake, torque.
  - Brake is converted every other slot; torque twice per table.
  - slot wraps 7->0.
- Undefined: 4-slot round-robin batt, curr, brake, torque.
  - slot wraps 3->0; slot[2] is held at 0.

Decomposition:
- Package a2d_pkg holds:
  - the state enum;
  - channel localparams and the vld bit indices;
  - both slot tables as constant arrays;
  - the interval terminal-count constants for FAST_SIM=0 and 1.
- One natural sub-module: a2d_interval_tmr.
  - Parameterised FAST_SIM; inputs en and clr; output tc.
  - Isolates pacing from the FSM.
- The SPI master remains a separate existing block.

Test Plan:
- Reset, then en=1 with a bench SPI model returning 16'h0ABC; FAST_SIM=1.
  - First wrt at 513±1 clks after reset release, cmd=16'h1800 (brake with A2D_BRAKE_PRIO_EN).
  - brake=12'hABC with vld[2] pulse after the second done.
- Run 8 conversions with A2D_BRAKE_PRIO_EN.
  - Channel order 3,0,3,1,3,4,3,4; brake updated 4 times; slot wraps to 0.
- Same run without the macro.
  - Order 0,1,3,4,0; slot sequence 0,1,2,3,0.
- Drop en during WAIT_CMD.
  - The read transaction and STORE still complete.
  - No further wrt for 2000 clks while en=0.
- Assert rst_n low during WAIT_READ after brake was 12'h900.
  - brake returns to 12'h000 asynchronously; wrt=0; slot=0; no vld pulse.
- Inject a spurious done in IDLE, and a done concurrent with wrt.
  - FSM does not advance; exactly two wrt pulses per conversion are observed.

Source files
------------

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion scheduler.
// Slot tables cover both builds; A2D_BRAKE_PRIO_EN selects the 8-slot brake-priority table.
package a2d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT_CMD,
        ST_GAP,
        ST_READ,
        ST_WAIT_READ,
        ST_STORE
    } state_e;

    localparam int unsigned RES_W  = 12;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 14;

    localparam logic [2:0] BATT_CH   = 3'd0;
    localparam logic [2:0] CURR_CH   = 3'd1;
    localparam logic [2:0] BRAKE_CH  = 3'd3;
    localparam logic [2:0] TORQUE_CH = 3'd4;

    localparam int unsigned VLD_BATT   = 0;
    localparam int unsigned VLD_CURR   = 1;
    localparam int unsigned VLD_BRAKE  = 2;
    localparam int unsigned VLD_TORQUE = 3;

    localparam int unsigned TC_SLOW = 16383;
    localparam int unsigned TC_FAST = 511;

    // Index 0 is the rightmost element of each packed table.
    localparam logic [7:0][2:0] PRIO_TBL = {TORQUE_CH, BRAKE_CH, TORQUE_CH, BRAKE_CH,
                                            CURR_CH,   BRAKE_CH, BATT_CH,   BRAKE_CH};
    localparam logic [3:0][2:0] RR_TBL   = {TORQUE_CH, BRAKE_CH, CURR_CH, BATT_CH};

    function automatic logic [1:0] ch_to_idx(input logic [2:0] ch);
        case (ch)
            CURR_CH:   return 2'(VLD_CURR);
            BRAKE_CH:  return 2'(VLD_BRAKE);
            TORQUE_CH: return 2'(VLD_TORQUE);
            default:   return 2'(VLD_BATT);
        endcase
    endfunction

endpackage

// File: rtl/a2d_conv_sched_if.sv
// Scheduler <-> SPI master transaction interface.
interface a2d_conv_sched_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/a2d_interval_tmr.sv
// Inter-conversion pacing timer: tc is a one-clk pulse at terminal count while enabled.
module a2d_interval_tmr
    import a2d_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = FAST_SIM ? CNT_W'(TC_FAST) : CNT_W'(TC_SLOW);

    logic [CNT_W-1:0] cnt_q;
    logic             tc_q;

    // Counter held at zero when disabled or while a conversion is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            if (!en || clr || tc_q) cnt_q <= '0;
            else                    cnt_q <= cnt_q + CNT_W'(1);
            tc_q <= en && !clr && !tc_q && (cnt_q == TC_VAL - CNT_W'(1));
        end
    end

    assign tc = tc_q;

endmodule

// File: rtl/a2d_conv_sched.sv
// A2D conversion scheduler: paces conversions, runs command/read SPI pair, holds per-channel results.
// Build option A2D_BRAKE_PRIO_EN: 8-slot brake-priority table instead of 4-slot round-robin.
module a2d_conv_sched
    import a2d_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    a2d_conv_sched_if.master      spi,
    output logic [RES_W-1:0]      batt,
    output logic [RES_W-1:0]      curr,
    output logic [RES_W-1:0]      brake,
    output logic [RES_W-1:0]      torque,
    output logic [NUM_CH-1:0]     vld,
    output logic [2:0]            slot
);

    state_e                        state_q, state_d;
    logic                          tc, tmr_clr;
    logic [2:0]                    slot_q, slot_d, slot_nxt, cur_ch;
    logic [1:0]                    cur_idx;
    logic                          wrt_q, wrt_d;
    logic [15:0]                   cmd_q, cmd_d;
    logic [NUM_CH-1:0]             vld_q, vld_d;
    logic [NUM_CH-1:0][RES_W-1:0]  res_q, res_d;
    logic                          unused_rd_hi;

`ifdef A2D_BRAKE_PRIO_EN
    assign cur_ch   = PRIO_TBL[slot_q];
    assign slot_nxt = slot_q + 3'd1;
`else
    assign cur_ch   = RR_TBL[slot_q[1:0]];
    assign slot_nxt = {1'b0, slot_q[1:0] + 2'd1};
`endif

    assign cur_idx      = ch_to_idx(cur_ch);
    assign tmr_clr      = (state_q != ST_IDLE);
    assign unused_rd_hi = ^spi.rd_data[15:12];

    a2d_interval_tmr #(.FAST_SIM(FAST_SIM)) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (tmr_clr),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // done is only honoured in the two wait states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (tc && en)  state_d = ST_CMD;
            ST_CMD:                      state_d = ST_WAIT_CMD;
            ST_WAIT_CMD:  if (spi.done)  state_d = ST_GAP;
            ST_GAP:                      state_d = ST_READ;
            ST_READ:                     state_d = ST_WAIT_READ;
            ST_WAIT_READ: if (spi.done)  state_d = ST_STORE;
            ST_STORE:                    state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so that they register in step with it.
    always_comb begin
        wrt_d  = (state_d == ST_CMD) || (state_d == ST_READ);
        cmd_d  = cmd_q;
        res_d  = res_q;
        vld_d  = '0;
        slot_d = slot_q;
        if (state_d == ST_CMD) cmd_d = {2'b00, cur_ch, 11'h000};
        if (state_d == ST_STORE) begin
            res_d[cur_idx] = spi.rd_data[RES_W-1:0];
            vld_d[cur_idx] = 1'b1;
        end
        if (state_q == ST_STORE) slot_d = slot_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt_q  <= 1'b0;
            cmd_q  <= '0;
            res_q  <= '0;
            vld_q  <= '0;
            slot_q <= '0;
        end else begin
            wrt_q  <= wrt_d;
            cmd_q  <= cmd_d;
            res_q  <= res_d;
            vld_q  <= vld_d;
            slot_q <= slot_d;
        end
    end

    assign spi.wrt = wrt_q;
    assign spi.cmd = cmd_q;
    assign batt    = res_q[VLD_BATT];
    assign curr    = res_q[VLD_CURR];
    assign brake   = res_q[VLD_BRAKE];
    assign torque  = res_q[VLD_TORQUE];
    assign vld     = vld_q;
    assign slot    = slot_q;

endmodule
